// File: rtl/alu_mod_sequencer.sv
// alu_mod_sequencer
// Multi-cycle controller that computes the unsigned remainder (ALU op 111)
// by borrowing the shared 32-bit ALU and running a restoring shift-subtract
// loop with it. Each iteration issues an ALU subtract (op 110) and picks the
// new partial remainder from the ALU result or the shifted value, depending on
// the carry-out.
//
// Optional feature, enabled by defining the macro EARLY_EXIT_EN:
//   a CHK state compares dividend against divisor before the loop starts.
//   When the dividend is already smaller, the remainder is the dividend
//   itself, and the operation finishes one edge after accept.
//
// WIDTH must be at least 2 (the shift path slices R[WIDTH-2:0]).
module alu_mod_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout
);

  // Iteration counter width; counts from WIDTH-1 down to 0.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0]    OP_IDLE   = 3'b000;
  localparam logic [2:0]    OP_SUB    = 3'b110;
  localparam logic [CW-1:0] COUNT_TOP = CW'(WIDTH - 1);

`ifdef EARLY_EXIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CHK  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
`endif

  state_t state_q, state_d;

  // Partial remainder, shifting dividend, latched divisor, and loop counter.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             div_zero_q, div_zero_d;

  // The partial remainder with the next dividend bit shifted in. The true
  // partial remainder is WIDTH+1 bits wide; its top bit is rem_q[WIDTH-1],
  // which is shifted out here.
  logic [WIDTH-1:0] rem_shifted;
  logic [WIDTH-1:0] rem_step;

  assign rem_shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  // Subtract when the lost top bit was set, because the value is then
  // certainly >= divisor, or when the ALU reports no borrow. In the first
  // case, alu_r is still the exact difference modulo 2^WIDTH, and the
  // difference is below the divisor, so it fits in WIDTH bits.
  assign rem_step = (rem_q[WIDTH-1] || alu_cout) ? alu_r : rem_shifted;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      count_q    <= count_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next-state, datapath update, and ALU drive for each state.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    count_d    = count_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;
    alu_op     = OP_IDLE;
    alu_a      = '0;
    alu_b      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d      = dividend;
          dvs_d      = divisor;
          rem_d      = '0;
          count_d    = COUNT_TOP;
          div_zero_d = 1'b0;
          if (divisor == '0) begin
            // x mod 0 returns x and flags the case, without using the ALU.
            result_d   = dividend;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            busy_d  = 1'b1;
`ifdef EARLY_EXIT_EN
            state_d = CHK;
`else
            state_d = RUN;
`endif
          end
        end
      end

`ifdef EARLY_EXIT_EN
      CHK: begin
        alu_op = OP_SUB;
        alu_a  = quo_q;
        alu_b  = dvs_q;
        if (!alu_cout) begin
          // A borrow means dividend < divisor, so the remainder is the dividend.
          result_d = quo_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = RUN;
        end
      end
`endif

      RUN: begin
        alu_op  = OP_SUB;
        alu_a   = rem_shifted;
        alu_b   = dvs_q;
        rem_d   = rem_step;
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          result_d = rem_step;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_mod_sequencer.sv
// tb_alu_mod_sequencer
// Directed-vector bench for alu_mod_sequencer. It uses a behavioural ALU model
// and a scoreboard queue. The stimulus process pushes expected
// {result, div_zero, done edge} entries. The monitor process pops one entry
// and compares it every time the DUT pulses done.
// Build with EARLY_EXIT_EN defined to check the early-exit latencies.
module tb_alu_mod_sequencer;

  localparam int WIDTH = 32;

  // Latency is counted as the number of clock edges from the accept edge to
  // the edge that raises done.
`ifdef EARLY_EXIT_EN
  localparam int RUN_LAT   = 33;
  localparam int SMALL_LAT = 1;
`else
  localparam int RUN_LAT   = 32;
  localparam int SMALL_LAT = 32;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_cout;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             dz;
    int               due_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_count = 0;

  alu_mod_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .alu_cout (alu_cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Behavioural 32-bit ALU. Subtract is a + ~b + 1, so carry-out = no borrow.
  always_comb begin
    alu_r    = '0;
    alu_cout = 1'b0;
    case (alu_op)
      3'b110:  {alu_cout, alu_r} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      3'b000:  alu_r = alu_a & alu_b;
      default: alu_r = alu_a | alu_b;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one request for a single accept edge; optionally queue its expectation.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] exp_res, input logic exp_dz,
                               input int lat, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back('{res: exp_res, dz: exp_dz, due_edge: edge_count + lat});
    checkOutput("busy_after_accept", {63'd0, busy}, {63'd0, (b != '0)});
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d pending results, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 result=0x%0h, expected no done", result);
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", {32'd0, result}, {32'd0, e.res});
        checkOutput("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        checkOutput("done_edge", 64'(edge_count), 64'(e.due_edge));
      end
    end
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_result", {32'd0, result}, 64'd0);
    checkOutput("reset_div_zero", {63'd0, div_zero}, 64'd0);
    checkOutput("idle_alu_op", {61'd0, alu_op}, 64'd0);
    checkOutput("idle_alu_a", {32'd0, alu_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 100 mod 7 = 2. Busy must stay high for the full latency.
    applyStimulus(32'd100, 32'd7, 32'd2, 1'b0, RUN_LAT, 1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("busy_cycles", 64'(cnt), 64'(RUN_LAT));
    waitDrain("basic");

    // A wide divisor exercises the lost-top-bit subtract path.
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, RUN_LAT, 1'b1);
    waitDrain("wide_div");
    applyStimulus(32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, RUN_LAT, 1'b1);
    waitDrain("div16");

    // Divide by zero: done on the accept edge, busy never rises.
    applyStimulus(32'h1234, 32'd0, 32'h1234, 1'b1, 0, 1'b1);
    waitDrain("div_zero");

    // Small dividends: the remainder is the dividend. This also checks that
    // div_zero clears after the divide-by-zero case.
    applyStimulus(32'd5, 32'd9, 32'd5, 1'b0, SMALL_LAT, 1'b1);
    waitDrain("small");
    applyStimulus(32'd0, 32'd5, 32'd0, 1'b0, SMALL_LAT, 1'b1);
    waitDrain("zero_dividend");
    applyStimulus(32'd12345678, 32'hFFFF_FFFF, 32'd12345678, 1'b0, SMALL_LAT, 1'b1);
    waitDrain("max_divisor");
    applyStimulus(32'd1000, 32'd1000, 32'd0, 1'b0, RUN_LAT, 1'b1);
    waitDrain("equal");
    applyStimulus(32'hDEAD_BEEF, 32'd1, 32'd0, 1'b0, RUN_LAT, 1'b1);
    waitDrain("div_one");

    // A start while busy is ignored, and changed operands have no effect.
    // A start during the done cycle is accepted.
    applyStimulus(32'd100, 32'd7, 32'd2, 1'b0, RUN_LAT, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(32'd50, 32'd3, 32'd2, 1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    checkOutput("done_seen", {63'd0, done}, 64'd1);
    applyStimulus(32'd23, 32'd7, 32'd2, 1'b0, RUN_LAT, 1'b1);
    waitDrain("back_to_back");

    // Reset in the middle of RUN must clear outputs at once, and the
    // abandoned operation must never produce done.
    applyStimulus(32'hFFFF, 32'd3, 32'd0, 1'b0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrun_reset_done", {63'd0, done}, 64'd0);
    checkOutput("midrun_reset_result", {32'd0, result}, 64'd0);
    checkOutput("midrun_reset_alu_op", {61'd0, alu_op}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("post_reset_busy", {63'd0, busy}, 64'd0);
    applyStimulus(32'd17, 32'd5, 32'd2, 1'b0, RUN_LAT, 1'b1);
    waitDrain("after_reset");

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
